// File: rtl/sram_model_pkg.sv
// Shared constants for the SRAM responder: bus widths, burst FSM
// encodings, default block length and the MIX word halfword split.
package sram_model_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  localparam int BLOCK_LEN_DEF = 200;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  localparam int MIX_LO_MSB = 15;
  localparam int MIX_LO_LSB = 0;
  localparam int MIX_HI_MSB = 30;
  localparam int MIX_HI_LSB = 16;

  function automatic logic [15:0] mix_lo(input logic [30:0] w);
    return w[MIX_LO_MSB:MIX_LO_LSB];
  endfunction

  function automatic logic [15:0] mix_hi(input logic [30:0] w);
    return {1'b0, w[MIX_HI_MSB:MIX_HI_LSB]};
  endfunction

endpackage

// File: rtl/sram_model_mon.sv
// Burst protocol monitor: IDLE/WR/RD FSM, halfword counter, sticky errors.
// Ports: SRAM control/address in; idle, burst_done/len/wr, err_* out.
module sram_model_mon
  import sram_model_pkg::*;
#(
  parameter int DEPTH_W   = 12,
  parameter int BLOCK_LEN = BLOCK_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_cen,
  input  logic               i_wen,
  input  logic               i_oen,
  input  logic [SRAM_AW-1:0] i_addr,
  output logic               o_idle,
  output logic               o_burst_done,
  output logic [8:0]         o_burst_len,
  output logic               o_burst_wr,
  output logic               o_err_contention,
  output logic               o_err_range,
  output logic               o_err_len,
  output logic               o_err_mix
);

  localparam logic [8:0] LEN9 = 9'(BLOCK_LEN);

  logic [1:0]         r_state;
  logic [8:0]         r_cnt;
  logic [SRAM_AW-1:0] r_last;
  logic               r_done;
  logic [8:0]         r_len;
  logic               r_wr;
  logic               r_e_con;
  logic               r_e_rng;
  logic               r_e_len;
  logic               r_e_mix;

  logic               w_wr;
  logic               w_rd;
  logic               w_con;
  logic               w_hi;
  logic [8:0]         w_cnt_nx;
  logic [1:0]         w_nx;
  logic               w_acc;
  logic               w_mix;
  logic               w_end;

  assign w_wr     = ~i_cen & ~i_wen;
  assign w_rd     = ~i_cen & ~i_oen & i_wen;
  assign w_con    = ~i_cen & ~i_wen & ~i_oen;
  assign w_hi     = (i_addr >> DEPTH_W) != '0;
  assign w_cnt_nx = (&r_cnt) ? r_cnt : r_cnt + 9'd1;

  always_comb begin
    w_nx  = r_state;
    w_acc = 1'b0;
    w_mix = 1'b0;
    w_end = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_wr) begin
          w_nx  = ST_WR;
          w_acc = 1'b1;
        end else if (w_rd) begin
          w_nx  = ST_RD;
          w_acc = 1'b1;
        end
      end
      ST_WR: begin
        if (i_cen) begin
          w_nx  = ST_IDLE;
          w_end = 1'b1;
        end else if (~i_wen) begin
          w_acc = 1'b1;
        end else if (w_rd) begin
          w_mix = 1'b1;
        end
      end
      ST_RD: begin
        if (i_cen) begin
          w_nx  = ST_IDLE;
          w_end = 1'b1;
        end else if (~i_wen) begin
          w_mix = 1'b1;
        end else if (w_rd && i_addr != r_last) begin
          w_acc = 1'b1;
        end
      end
      default: w_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_last  <= '0;
      r_done  <= 1'b0;
      r_len   <= '0;
      r_wr    <= 1'b0;
      r_e_con <= 1'b0;
      r_e_rng <= 1'b0;
      r_e_len <= 1'b0;
      r_e_mix <= 1'b0;
    end else begin
      r_state <= w_nx;
      r_done  <= w_end;
      if (r_state == ST_IDLE) begin
        r_cnt <= {8'd0, w_acc};
      end else if (w_acc) begin
        r_cnt <= w_cnt_nx;
      end
      if (w_acc) r_last <= i_addr;
      if (w_end) begin
        r_len <= r_cnt;
        r_wr  <= (r_state == ST_WR);
        if (r_cnt != LEN9) r_e_len <= 1'b1;
      end
      if (w_acc & w_hi) r_e_rng <= 1'b1;
      if (w_con) r_e_con <= 1'b1;
      if (w_mix) r_e_mix <= 1'b1;
    end
  end

  assign o_idle           = (r_state == ST_IDLE);
  assign o_burst_done     = r_done;
  assign o_burst_len      = r_len;
  assign o_burst_wr       = r_wr;
  assign o_err_contention = r_e_con;
  assign o_err_range      = r_e_rng;
  assign o_err_len        = r_e_len;
  assign o_err_mix        = r_e_mix;

endmodule

// File: rtl/sram_model.sv
// Block-RAM emulation of the external 16-bit async SRAM with backdoor.
// Ports: SRAM pins (addr/data/wen/oen/cen), bd_* backdoor, monitor outs.
module sram_model
  import sram_model_pkg::*;
#(
  parameter int DEPTH_W   = 12,
  parameter int BLOCK_LEN = BLOCK_LEN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SRAM_AW-1:0] sram_addr,
  inout  wire  [SRAM_DW-1:0] sram_data,
  input  logic               sram_wen,
  input  logic               sram_oen,
  input  logic               sram_cen,
  input  logic               bd_req,
  input  logic               bd_we,
  input  logic [DEPTH_W-1:0] bd_addr,
  input  logic [SRAM_DW-1:0] bd_wdata,
  output logic               bd_ack,
  output logic [SRAM_DW-1:0] bd_rdata,
  output logic               burst_done,
  output logic [8:0]         burst_len,
  output logic               burst_wr,
  output logic               err_contention,
  output logic               err_range,
  output logic               err_len,
  output logic               err_mix
);

  localparam int DEPTH = 1 << DEPTH_W;

  logic [SRAM_DW-1:0] r_mem [DEPTH];
  logic [SRAM_DW-1:0] r_rd_q;
  logic               r_drive_en;
  logic               r_bd_ack;
  logic [SRAM_DW-1:0] r_bd_rdata;

  logic [DEPTH_W-1:0] w_idx;
  logic               w_sram_we;
  logic               w_idle;
  logic               w_bd_go;

  // upper address bits alias; the monitor flags them
  assign w_idx     = sram_addr[DEPTH_W-1:0];
  assign w_sram_we = ~sram_cen & ~sram_wen;
  // ~r_bd_ack stops a still-high req in the ack cycle re-triggering
  assign w_bd_go   = bd_req & w_idle & sram_cen & ~r_bd_ack;

  always_ff @(posedge clk) begin
    if (w_sram_we) begin
      r_mem[w_idx] <= sram_data;
    end else if (w_bd_go & bd_we) begin
      r_mem[bd_addr] <= bd_wdata;
    end
    r_rd_q <= r_mem[w_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drive_en <= 1'b0;
      r_bd_ack   <= 1'b0;
      r_bd_rdata <= '0;
    end else begin
      r_drive_en <= ~sram_cen & ~sram_oen & sram_wen;
      r_bd_ack   <= w_bd_go;
      if (w_bd_go) r_bd_rdata <= r_mem[bd_addr];
    end
  end

  assign sram_data = r_drive_en ? r_rd_q : {SRAM_DW{1'bz}};
  assign bd_ack    = r_bd_ack;
  assign bd_rdata  = r_bd_rdata;

  sram_model_mon #(
    .DEPTH_W   (DEPTH_W),
    .BLOCK_LEN (BLOCK_LEN)
  ) u_mon (
    .clk              (clk),
    .rst_n            (reset),
    .i_cen            (sram_cen),
    .i_wen            (sram_wen),
    .i_oen            (sram_oen),
    .i_addr           (sram_addr),
    .o_idle           (w_idle),
    .o_burst_done     (burst_done),
    .o_burst_len      (burst_len),
    .o_burst_wr       (burst_wr),
    .o_err_contention (err_contention),
    .o_err_range      (err_range),
    .o_err_len        (err_len),
    .o_err_mix        (err_mix)
  );

endmodule

// File: tb/tb_sram_model.sv
// Bench for sram_model: backdoor vector table, controller bursts,
// contention, length, range, mixing and mid-burst reset sequences.
module tb_sram_model;
  import sram_model_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] sram_addr;
  wire  [15:0] sram_data;
  logic        sram_wen, sram_oen, sram_cen;
  logic        bd_req, bd_we;
  logic [11:0] bd_addr;
  logic [15:0] bd_wdata;
  logic        bd_ack;
  logic [15:0] bd_rdata;
  logic        burst_done;
  logic [8:0]  burst_len;
  logic        burst_wr;
  logic        err_contention, err_range, err_len, err_mix;

  logic        tb_drv;
  logic [15:0] tb_dq;
  assign sram_data = tb_drv ? tb_dq : 16'hzzzz;

  always #5 clk = ~clk;

  sram_model dut (
    .clk            (clk),
    .reset          (reset),
    .sram_addr      (sram_addr),
    .sram_data      (sram_data),
    .sram_wen       (sram_wen),
    .sram_oen       (sram_oen),
    .sram_cen       (sram_cen),
    .bd_req         (bd_req),
    .bd_we          (bd_we),
    .bd_addr        (bd_addr),
    .bd_wdata       (bd_wdata),
    .bd_ack         (bd_ack),
    .bd_rdata       (bd_rdata),
    .burst_done     (burst_done),
    .burst_len      (burst_len),
    .burst_wr       (burst_wr),
    .err_contention (err_contention),
    .err_range      (err_range),
    .err_len        (err_len),
    .err_mix        (err_mix)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] model [4096];
  logic [15:0] exp_q [$];

  typedef struct {
    bit          we;
    logic [11:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } bd_vec_t;

  bd_vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk_undriven(input string nm);
    checks++;
    if (!(sram_data === 16'hzzzz || sram_data === 16'h0000)) begin
      failures++;
      $display("FAIL %s got=%h exp=undriven", nm, sram_data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    sram_oen = 1'b1;
    tb_drv   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  function automatic logic [15:0] hw(input int j);
    logic [30:0] w;
    w = 31'(j / 2) + 31'h4000_0000;
    return j[0] ? mix_hi(w) : mix_lo(w);
  endfunction

  task automatic bd_op(input bit we, input logic [11:0] a,
                       input logic [15:0] d, output logic [15:0] rd);
    int n;
    bd_req   = 1'b1;
    bd_we    = we;
    bd_addr  = a;
    bd_wdata = d;
    n = 0;
    while (!bd_ack && n < 20) begin
      tick();
      n++;
    end
    rd     = bd_rdata;
    bd_req = 1'b0;
    chk("bd_ack_latency", 32'(n), 32'd1);
    tick();
    chk("bd_ack_pulse", {31'd0, bd_ack}, 32'd0);
    if (we) model[a] = d;
  endtask

  task automatic wr_seq(input logic [17:0] base, input int n);
    for (int j = 0; j < n; j++) begin
      sram_cen  = 1'b0;
      sram_wen  = 1'b0;
      sram_oen  = 1'b1;
      sram_addr = base + 18'(j);
      tb_drv    = 1'b1;
      tb_dq     = hw(j);
      model[sram_addr[11:0]] = tb_dq;
      tick();
    end
    idle_bus();
  endtask

  task automatic rd_seq(input logic [17:0] base, input int n,
                        input bit words);
    logic [15:0] lo;
    logic [15:0] got;
    lo = '0;
    for (int j = 0; j < n; j++) begin
      sram_cen  = 1'b0;
      sram_oen  = 1'b0;
      sram_wen  = 1'b1;
      tb_drv    = 1'b0;
      sram_addr = base + 18'(j);
      exp_q.push_back(model[sram_addr[11:0]]);
      tick();
      got = sram_data;
      chk("rd_data", {16'd0, got}, {16'd0, exp_q.pop_front()});
      if (words && j[0]) begin
        chk("rd_word", {1'b0, got[14:0], lo},
            32'(j / 2) + 32'h4000_0000);
      end
      lo = got;
    end
  endtask

  logic [15:0] rdv;

  initial begin
    tbl[0] = '{1'b1, 12'h100, 16'h1234, 16'h0000};
    tbl[1] = '{1'b0, 12'h100, 16'h0000, 16'h1234};
    tbl[2] = '{1'b1, 12'h7FF, 16'hA5A5, 16'h0000};
    tbl[3] = '{1'b1, 12'hFFF, 16'h5A5A, 16'h0000};
    tbl[4] = '{1'b0, 12'h7FF, 16'h0000, 16'hA5A5};
    tbl[5] = '{1'b0, 12'hFFF, 16'h0000, 16'h5A5A};
    tbl[6] = '{1'b1, 12'h005, 16'h4110, 16'h0000};
    tbl[7] = '{1'b0, 12'h005, 16'h0000, 16'h4110};

    reset     = 1'b0;
    sram_addr = '0;
    tb_dq     = '0;
    bd_req    = 1'b0;
    bd_we     = 1'b0;
    bd_addr   = '0;
    bd_wdata  = '0;
    idle_bus();
    tick();
    tick();
    chk("reset_outs",
        {bd_ack, bd_rdata, burst_done, burst_len, burst_wr,
         err_contention, err_range, err_len, err_mix}, 32'd0);
    chk_undriven("reset_z");
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      bd_op(tbl[i].we, tbl[i].a, tbl[i].d, rdv);
      if (!tbl[i].we) chk("bd_rdata", {16'd0, rdv}, {16'd0, tbl[i].exp});
    end

    wr_seq(18'h100, 200);
    tick();
    chk("wr_done", {31'd0, burst_done}, 32'd1);
    chk("wr_len", {23'd0, burst_len}, 32'd200);
    chk("wr_dir", {31'd0, burst_wr}, 32'd1);
    chk("wr_flags", {28'd0, err_contention, err_range, err_len, err_mix},
        32'd0);
    tick();
    chk("wr_done_pulse", {31'd0, burst_done}, 32'd0);

    bd_op(1'b0, 12'h101, 16'h0, rdv);
    chk("dump_101", {16'd0, rdv}, 32'h4000);
    bd_op(1'b0, 12'h100, 16'h0, rdv);
    chk("dump_100", {16'd0, rdv}, 32'h0000);
    bd_op(1'b0, 12'h1C6, 16'h0, rdv);
    chk("dump_1c6", {16'd0, rdv}, 32'h0063);

    rd_seq(18'h100, 200, 1'b1);
    idle_bus();
    tick();
    chk("rd_done", {31'd0, burst_done}, 32'd1);
    chk("rd_len", {23'd0, burst_len}, 32'd200);
    chk("rd_dir", {31'd0, burst_wr}, 32'd0);
    chk("rd_flags", {28'd0, err_contention, err_range, err_len, err_mix},
        32'd0);
    chk_undriven("rd_release");

    sram_addr = 18'h5;
    sram_cen  = 1'b0;
    sram_wen  = 1'b0;
    sram_oen  = 1'b0;
    tb_drv    = 1'b1;
    tb_dq     = 16'hBEEF;
    model[5]  = 16'hBEEF;
    tick();
    chk("cont_flag", {31'd0, err_contention}, 32'd1);
    chk("cont_bus", {16'd0, sram_data}, 32'hBEEF);
    idle_bus();
    tick();
    chk_undriven("cont_release");
    bd_op(1'b0, 12'h005, 16'h0, rdv);
    chk("cont_mem", {16'd0, rdv}, 32'hBEEF);

    do_reset();
    chk("rst_flags", {28'd0, err_contention, err_range, err_len, err_mix},
        32'd0);
    wr_seq(18'h200, 150);
    tick();
    chk("short_done", {31'd0, burst_done}, 32'd1);
    chk("short_len", {23'd0, burst_len}, 32'd150);
    chk("short_errlen", {31'd0, err_len}, 32'd1);
    chk("short_errrng", {31'd0, err_range}, 32'd0);

    do_reset();
    wr_seq(18'h300, 2);
    sram_cen = 1'b0;
    sram_oen = 1'b0;
    sram_wen = 1'b1;
    tick();
    chk("mix_flag", {31'd0, err_mix}, 32'd1);
    idle_bus();
    tick();
    chk("mix_len", {23'd0, burst_len}, 32'd2);

    do_reset();
    sram_addr = 18'h3F000;
    sram_cen  = 1'b0;
    sram_wen  = 1'b0;
    tb_drv    = 1'b1;
    tb_dq     = 16'h7777;
    tick();
    chk("range_flag", {31'd0, err_range}, 32'd1);
    idle_bus();
    tick();
    bd_op(1'b0, 12'h000, 16'h0, rdv);
    chk("range_alias", {16'd0, rdv}, 32'h7777);

    do_reset();
    rd_seq(18'h100, 4, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_undriven("rst_mid_z");
    chk("rst_mid_outs",
        {burst_done, burst_len, burst_wr,
         err_contention, err_range, err_len, err_mix}, 32'd0);
    idle_bus();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_done", {31'd0, burst_done}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
